fib_controller: RTL

FIB_CONTROLLER -- requirements
Module: fib_controller

---
 rtl/fib_pkg.sv | 60 ++++++
 rtl/fib_ctrl_decode.sv | 117 +++++++++++
 rtl/fib_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and datapath select encodings for the Fibonacci controller.
package fib_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FLUSH    = 4'd1,
        ST_LOAD     = 4'd2,
        ST_CALL     = 4'd3,
        ST_PUSHF    = 4'd4,
        ST_PUSHN    = 4'd5,
        ST_PUSHR    = 4'd6,
        ST_DEC      = 4'd7,
        ST_RET      = 4'd8,
        ST_POPR     = 4'd9,
        ST_POPN     = 4'd10,
        ST_POPF     = 4'd11,
        ST_DISPATCH = 4'd12,
        ST_DONE     = 4'd13
    } state_t;

    localparam logic [1:0] SS_F      = 2'd0;
    localparam logic [1:0] SS_N      = 2'd1;
    localparam logic [1:0] SS_RES    = 2'd2;

    localparam logic [1:0] ADDL_ZERO = 2'd0;
    localparam logic [1:0] ADDL_N    = 2'd1;
    localparam logic [1:0] ADDL_RES  = 2'd2;

    localparam logic [1:0] ADDR_RET  = 2'd1;
    localparam logic [1:0] ADDR_ONE  = 2'd2;
    localparam logic [1:0] ADDR_TWO  = 2'd3;

    localparam logic [1:0] RETS_ONE  = 2'd0;
    localparam logic [1:0] RETS_SUM  = 2'd1;

    localparam logic ADDSUB_ADD = 1'b0;
    localparam logic ADDSUB_SUB = 1'b1;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic       addsub;
        logic       ress;
        logic       resld;
        logic       resrst;
        logic       retld;
        logic       retrst;
        logic       ns;
        logic       nld;
        logic       nrst;
        logic       fs;
        logic       fld;
        logic       frst;
        logic [1:0] rets;
        logic [1:0] addrs;
        logic [1:0] addls;
        logic [1:0] ss;
    } ctrl_t;

endpackage

// File: rtl/fib_ctrl_decode.sv
// Combinational decode of controller state and datapath status into datapath controls.
module fib_ctrl_decode
    import fib_pkg::*;
(
    input  state_t i_state,
    input  logic   i_go,
    input  logic   i_cnt_zero,
    input  logic   i_f_zero,
    input  logic   i_lt,
    input  logic   i_eq,
    input  logic   i_ready,
    output ctrl_t  o_ctrl
);

    // Per-state control decode; everything idles at zero unless asserted here
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_IDLE: begin
                if (i_go && i_ready) begin
                    o_ctrl.nrst   = 1'b1;
                    o_ctrl.resrst = 1'b1;
                    o_ctrl.retrst = 1'b1;
                    o_ctrl.frst   = 1'b1;
                end else begin
                    o_ctrl.nrst   = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (!i_ready) begin
                    o_ctrl.pop    = 1'b1;
                end else begin
                    o_ctrl.nrst   = 1'b1;
                    o_ctrl.resrst = 1'b1;
                    o_ctrl.retrst = 1'b1;
                    o_ctrl.frst   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!i_cnt_zero) begin
                    o_ctrl.addls  = ADDL_N;
                    o_ctrl.addrs  = ADDR_ONE;
                    o_ctrl.addsub = ADDSUB_ADD;
                    o_ctrl.ns     = 1'b0;
                    o_ctrl.nld    = 1'b1;
                end else begin
                    o_ctrl.nld    = 1'b0;
                end
            end
            ST_CALL: begin
                if (i_lt || i_eq) begin
                    o_ctrl.rets  = RETS_ONE;
                    o_ctrl.retld = 1'b1;
                end else begin
                    o_ctrl.retld = 1'b0;
                end
            end
            ST_PUSHF: begin
                o_ctrl.push = 1'b1;
                o_ctrl.ss   = SS_F;
            end
            ST_PUSHN: begin
                o_ctrl.push = 1'b1;
                o_ctrl.ss   = SS_N;
            end
            ST_PUSHR: begin
                o_ctrl.push = 1'b1;
                o_ctrl.ss   = SS_RES;
            end
            ST_DEC: begin
                o_ctrl.addls  = ADDL_N;
                o_ctrl.addrs  = i_f_zero ? ADDR_ONE : ADDR_TWO;
                o_ctrl.addsub = ADDSUB_SUB;
                o_ctrl.ns     = 1'b0;
                o_ctrl.nld    = 1'b1;
                o_ctrl.frst   = 1'b1;
            end
            ST_POPR: begin
                o_ctrl.pop   = 1'b1;
                o_ctrl.ress  = 1'b1;
                o_ctrl.resld = 1'b1;
            end
            ST_POPN: begin
                o_ctrl.pop = 1'b1;
                o_ctrl.ns  = 1'b1;
                o_ctrl.nld = 1'b1;
            end
            ST_POPF: begin
                o_ctrl.pop = 1'b1;
                o_ctrl.fs  = 1'b1;
                o_ctrl.fld = 1'b1;
            end
            ST_DISPATCH: begin
                // First return of a frame saves fib(n-1) and schedules the n-2 call
                if (i_f_zero) begin
                    o_ctrl.addls  = ADDL_ZERO;
                    o_ctrl.addrs  = ADDR_RET;
                    o_ctrl.addsub = ADDSUB_ADD;
                    o_ctrl.ress   = 1'b0;
                    o_ctrl.resld  = 1'b1;
                    o_ctrl.fs     = 1'b0;
                    o_ctrl.fld    = 1'b1;
                end else begin
                    o_ctrl.addls  = ADDL_RES;
                    o_ctrl.addrs  = ADDR_RET;
                    o_ctrl.addsub = ADDSUB_ADD;
                    o_ctrl.rets   = RETS_SUM;
                    o_ctrl.retld  = 1'b1;
                end
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/fib_controller.sv
// Recursive Fibonacci controller driving an external stack/adder datapath.
// Optional argument range check enabled by defining FIB_CTRL_NCHECK_EN.
module fib_controller
    import fib_pkg::*;
#(
    parameter int WORDSIZE = 8,
    parameter int MAX_N    = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WORDSIZE-1:0] nin,
    output logic                busy,
    output logic                done,
`ifdef FIB_CTRL_NCHECK_EN
    output logic                err,
`endif
    output logic                push,
    output logic                pop,
    output logic                addsub,
    output logic                ress,
    output logic                resld,
    output logic                resrst,
    output logic                retld,
    output logic                retrst,
    output logic                ns,
    output logic                nld,
    output logic                nrst,
    output logic                fs,
    output logic                fld,
    output logic                frst,
    output logic [1:0]          rets,
    output logic [1:0]          addrs,
    output logic [1:0]          addls,
    output logic [1:0]          ss,
    input  logic                lt,
    input  logic                gt,
    input  logic                eq,
    input  logic                ready,
    input  logic [WORDSIZE-1:0] f,
    input  logic [WORDSIZE-1:0] n
);

    localparam logic [WORDSIZE-1:0] MAX_N_W = WORDSIZE'(MAX_N);

    state_t              r_state;
    state_t              w_next_state;
    logic [WORDSIZE-1:0] r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                w_start_idle;
    logic                w_accept;
    logic                w_cnt_zero;
    logic                w_f_zero;
    logic                w_unused;
    ctrl_t               w_ctrl;

    // Gating with rst keeps every control low while reset is held
    assign w_start_idle = start && rst && (r_state == ST_IDLE);
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_f_zero     = (f == '0);

`ifdef FIB_CTRL_NCHECK_EN
    logic r_err;
    logic w_reject;
    assign w_accept = w_start_idle && (nin <= MAX_N_W);
    assign w_reject = w_start_idle && (nin > MAX_N_W);
    assign err      = r_err;
    assign w_unused = ^n;
`else
    assign w_accept = w_start_idle;
    assign w_unused = ^{n, MAX_N_W};
`endif

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_next_state = ready ? ST_LOAD : ST_FLUSH;
                         else          w_next_state = ST_IDLE;
            ST_FLUSH:    if (ready)    w_next_state = ST_LOAD;
                         else          w_next_state = ST_FLUSH;
            ST_LOAD:     if (w_cnt_zero) w_next_state = ST_CALL;
                         else            w_next_state = ST_LOAD;
            ST_CALL:     if (lt || eq)   w_next_state = ST_RET;
                         else if (gt)    w_next_state = ST_PUSHF;
                         else            w_next_state = ST_CALL;
            ST_PUSHF:    w_next_state = ST_PUSHN;
            ST_PUSHN:    w_next_state = ST_PUSHR;
            ST_PUSHR:    w_next_state = ST_DEC;
            ST_DEC:      w_next_state = ST_CALL;
            ST_RET:      if (ready)    w_next_state = ST_DONE;
                         else          w_next_state = ST_POPR;
            ST_POPR:     w_next_state = ST_POPN;
            ST_POPN:     w_next_state = ST_POPF;
            ST_POPF:     w_next_state = ST_DISPATCH;
            ST_DISPATCH: if (w_f_zero) w_next_state = ST_PUSHF;
                         else          w_next_state = ST_RET;
            ST_DONE:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // State, load counter and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef FIB_CTRL_NCHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_DONE);
`ifdef FIB_CTRL_NCHECK_EN
            r_err   <= w_reject;
`endif
            if (w_accept) begin
                r_cnt <= nin;
            end else if ((r_state == ST_LOAD) && !w_cnt_zero) begin
                r_cnt <= r_cnt - WORDSIZE'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    fib_ctrl_decode u_decode (
        .i_state    (r_state),
        .i_go       (w_accept),
        .i_cnt_zero (w_cnt_zero),
        .i_f_zero   (w_f_zero),
        .i_lt       (lt),
        .i_eq       (eq),
        .i_ready    (ready),
        .o_ctrl     (w_ctrl)
    );

    assign busy   = r_busy;
    assign done   = r_done;
    assign push   = w_ctrl.push;
    assign pop    = w_ctrl.pop;
    assign addsub = w_ctrl.addsub;
    assign ress   = w_ctrl.ress;
    assign resld  = w_ctrl.resld;
    assign resrst = w_ctrl.resrst;
    assign retld  = w_ctrl.retld;
    assign retrst = w_ctrl.retrst;
    assign ns     = w_ctrl.ns;
    assign nld    = w_ctrl.nld;
    assign nrst   = w_ctrl.nrst;
    assign fs     = w_ctrl.fs;
    assign fld    = w_ctrl.fld;
    assign frst   = w_ctrl.frst;
    assign rets   = w_ctrl.rets;
    assign addrs  = w_ctrl.addrs;
    assign addls  = w_ctrl.addls;
    assign ss     = w_ctrl.ss;

endmodule
